// File: rtl/rf_writeback_queue.sv
// Write-side front end of the register file: accepts ALU and load results,
// queues them in order and drains one entry per cycle onto the RF write port.
// Two combinational lookups expose the newest pending value per register.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_rd,
  input  logic [DW-1:0]            ld_data,
  input  logic                     wb_hold,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wa,
  output logic [DW-1:0]            rf_wd,
  input  logic [AW-1:0]            q1_addr,
  output logic                     q1_hit,
  output logic [DW-1:0]            q1_data,
  input  logic [AW-1:0]            q2_addr,
  output logic                     q2_hit,
  output logic [DW-1:0]            q2_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          alu_fire, ld_fire;
  logic [AW-1:0] enq_rd;
  logic [DW-1:0] enq_data;
  logic          push, pop;
  logic [PW-1:0] fw1_slot, fw2_slot;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign pending   = count_q;

  // ALU has fixed priority; the load path only sees ready when the ALU is idle.
  assign alu_ready = !rst && !full;
  assign ld_ready  = !rst && !full && !alu_valid;
  assign alu_fire  = alu_valid && alu_ready;
  assign ld_fire   = ld_valid && ld_ready;
  assign enq_rd    = alu_fire ? alu_rd   : ld_rd;
  assign enq_data  = alu_fire ? alu_data : ld_data;
  // Writes to x0 complete the handshake but are never stored.
  assign push      = (alu_fire || ld_fire) && (enq_rd != '0);

  // Reset also suppresses the write so a flushed head never reaches the RF.
  assign rf_we     = !rst && !empty && !wb_hold;
  assign pop       = rf_we;
  assign rf_wa     = empty ? '0 : rd_q[head_q];
  assign rf_wd     = empty ? '0 : data_q[head_q];

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; slot contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= enq_rd;
      data_q[tail_q] <= enq_data;
    end
  end

  // Query 1: walk oldest to newest so the newest match overwrites earlier ones.
  always_comb begin
    q1_hit   = 1'b0;
    q1_data  = '0;
    fw1_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fw1_slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (q1_addr != '0) && (rd_q[fw1_slot] == q1_addr)) begin
        q1_hit  = 1'b1;
        q1_data = data_q[fw1_slot];
      end
    end
  end

  // Query 2: same walk for the second decode read address.
  always_comb begin
    q2_hit   = 1'b0;
    q2_data  = '0;
    fw2_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fw2_slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (q2_addr != '0) && (rd_q[fw2_slot] == q2_addr)) begin
        q2_hit  = 1'b1;
        q2_data = data_q[fw2_slot];
      end
    end
  end

endmodule
